// File: rtl/param_pipe_ctrl_alu.sv
// Two-stage valid/ready ALU pipeline. S1 registers the operands and the mode.
// S2 computes the result, registers it, and owns a running accumulator for mode 5.
module param_pipe_ctrl_alu #(
  parameter int WIDTH = 16
) (
  input  logic             ppca_clk,
  input  logic             ppca_rst_n,
  input  logic             ppca_in_valid,
  output logic             ppca_in_ready,
  input  logic [WIDTH-1:0] ppca_data_in1,
  input  logic [WIDTH-1:0] ppca_data_in2,
  input  logic [2:0]       ppca_ctrl_mode,
  input  logic             ppca_acc_clr,
  output logic             ppca_out_valid,
  input  logic             ppca_out_ready,
  output logic [WIDTH-1:0] ppca_data_out,
  output logic             ppca_ovf
);

  logic             en_s;
  logic             s1_valid_r;
  logic [WIDTH-1:0] s1_a_r;
  logic [WIDTH-1:0] s1_b_r;
  logic [2:0]       s1_mode_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] data_out_r;
  logic             ovf_r;
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] acc_base_s;
  logic [WIDTH:0]   add_s;
  logic [WIDTH:0]   acc_sum_s;
  logic             a_gt_b_s;
  logic             acc_load_s;
  logic [WIDTH-1:0] res_s;
  logic             ovf_s;

  // The whole pipeline stalls together whenever a held result is not being taken.
  assign en_s           = !out_valid_r || ppca_out_ready;
  assign ppca_in_ready  = en_s;
  assign ppca_out_valid = out_valid_r;
  assign ppca_data_out  = data_out_r;
  assign ppca_ovf       = ovf_r;

  assign add_s      = {1'b0, s1_a_r} + {1'b0, s1_b_r};
  assign a_gt_b_s   = (s1_a_r > s1_b_r);
  // A clear on the same edge as a mode-5 load takes effect before the add.
  assign acc_base_s = ppca_acc_clr ? {WIDTH{1'b0}} : acc_r;
  assign acc_sum_s  = {1'b0, acc_base_s} + {1'b0, s1_a_r};
  assign acc_load_s = en_s && s1_valid_r && (s1_mode_r == 3'd5);

  // Result and flag computation from the S1 registers
  always_comb begin
    res_s = {WIDTH{1'b0}};
    ovf_s = 1'b0;
    case (s1_mode_r)
      3'd0: begin
        res_s = add_s[WIDTH-1:0];
        ovf_s = add_s[WIDTH];
      end
      3'd1: begin
        res_s = add_s[WIDTH] ? {WIDTH{1'b1}} : add_s[WIDTH-1:0];
        ovf_s = add_s[WIDTH];
      end
      3'd2: res_s = a_gt_b_s ? (s1_a_r - s1_b_r) : (s1_b_r - s1_a_r);
      3'd3: res_s = a_gt_b_s ? (s1_a_r & s1_b_r) : (s1_a_r ^ s1_b_r);
      3'd4: begin
        if (s1_b_r[0]) begin
          res_s = {s1_a_r[WIDTH-2:0], 1'b0};
          ovf_s = s1_a_r[WIDTH-1];
        end else begin
          res_s = {1'b0, s1_a_r[WIDTH-1:1]};
          ovf_s = s1_a_r[0];
        end
      end
      3'd5: begin
        res_s = acc_sum_s[WIDTH-1:0];
        ovf_s = acc_sum_s[WIDTH];
      end
      3'd6: res_s = a_gt_b_s ? s1_a_r : s1_b_r;
      3'd7: res_s = ~s1_a_r;
      default: begin
        res_s = {WIDTH{1'b0}};
        ovf_s = 1'b0;
      end
    endcase
  end

  // Stage 1: operand capture
  always_ff @(posedge ppca_clk or negedge ppca_rst_n) begin
    if (!ppca_rst_n) begin
      s1_valid_r <= 1'b0;
      s1_a_r     <= {WIDTH{1'b0}};
      s1_b_r     <= {WIDTH{1'b0}};
      s1_mode_r  <= 3'd0;
    end else if (en_s) begin
      s1_valid_r <= ppca_in_valid;
      if (ppca_in_valid) begin
        s1_a_r    <= ppca_data_in1;
        s1_b_r    <= ppca_data_in2;
        s1_mode_r <= ppca_ctrl_mode;
      end
    end
  end

  // Stage 2: result register; bubbles leave the last data and flag untouched
  always_ff @(posedge ppca_clk or negedge ppca_rst_n) begin
    if (!ppca_rst_n) begin
      out_valid_r <= 1'b0;
      data_out_r  <= {WIDTH{1'b0}};
      ovf_r       <= 1'b0;
    end else if (en_s) begin
      out_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        data_out_r <= res_s;
        ovf_r      <= ovf_s;
      end
    end
  end

  // Accumulator: loads on a mode-5 advance into S2, otherwise honours a bare clear
  always_ff @(posedge ppca_clk or negedge ppca_rst_n) begin
    if (!ppca_rst_n) begin
      acc_r <= {WIDTH{1'b0}};
    end else if (acc_load_s) begin
      acc_r <= acc_sum_s[WIDTH-1:0];
    end else if (ppca_acc_clr) begin
      acc_r <= {WIDTH{1'b0}};
    end
  end

endmodule

// File: tb/tb_param_pipe_ctrl_alu.sv
// Self-checking bench for param_pipe_ctrl_alu (WIDTH=16): a vector table and directed
// sequences push expectations into a scoreboard that an output monitor drains.
module tb_param_pipe_ctrl_alu;

  localparam int W = 16;

  typedef struct {
    logic [W-1:0] d;
    logic         o;
  } exp_t;

  typedef struct {
    logic [2:0]   mode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] d;
    logic         o;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] din1;
  logic [W-1:0] din2;
  logic [2:0]   mode;
  logic         acc_clr;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] dout;
  logic         ovf;

  int   checks = 0;
  int   errors = 0;
  int   pushed = 0;
  int   popped = 0;
  exp_t sb_q[$];
  vec_t vecs[14];

  param_pipe_ctrl_alu #(.WIDTH(W)) dut (
    .ppca_clk       (clk),
    .ppca_rst_n     (rst_n),
    .ppca_in_valid  (in_valid),
    .ppca_in_ready  (in_ready),
    .ppca_data_in1  (din1),
    .ppca_data_in2  (din2),
    .ppca_ctrl_mode (mode),
    .ppca_acc_clr   (acc_clr),
    .ppca_out_valid (out_valid),
    .ppca_out_ready (out_ready),
    .ppca_data_out  (dout),
    .ppca_ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference behaviour for every mode except the accumulator
  function automatic exp_t model(input logic [2:0] m, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t r;
    logic [W:0] s;
    s = 17'(a) + 17'(b);
    r.o = 1'b0;
    case (m)
      3'd0: begin r.d = s[W-1:0]; r.o = s[W]; end
      3'd1: begin r.d = s[W] ? 16'hFFFF : s[W-1:0]; r.o = s[W]; end
      3'd2: r.d = (a > b) ? a - b : b - a;
      3'd3: r.d = (a > b) ? (a & b) : (a ^ b);
      3'd4: begin
        if (b[0]) begin r.d = 16'(a * 16'd2); r.o = a[W-1]; end
        else      begin r.d = a / 16'd2;      r.o = a[0];   end
      end
      3'd6: r.d = (a >= b) ? a : b;
      3'd7: r.d = a ^ 16'hFFFF;
      default: r.d = 16'h0000;
    endcase
    return r;
  endfunction

  // Present one operation from posedge+1 until it is accepted; record its expectation
  task automatic send(input logic [2:0] m, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] d, input logic o);
    bit ok = 1'b0;
    exp_t e;
    in_valid = 1'b1;
    mode = m;
    din1 = a;
    din2 = b;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      if (in_ready) begin
        e.d = d;
        e.o = o;
        sb_q.push_back(e);
        pushed++;
        ok = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no accept, expected accept within 100 cycles");
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int t = 0; t < 60 && sb_q.size() != 0; t++) begin
      @(posedge clk); #1;
    end
    chk("drain_empty", 64'(sb_q.size()), 64'd0);
  endtask

  // Output monitor: every output transfer must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got data %0h, expected no result", dout);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        popped++;
        chk("out_data", 64'(dout), 64'(e.d));
        chk("out_ovf", 64'(ovf), 64'(e.o));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{3'd0, 16'hFFFF, 16'h0002, 16'h0001, 1'b1};
    vecs[1]  = '{3'd0, 16'h1234, 16'h1111, 16'h2345, 1'b0};
    vecs[2]  = '{3'd1, 16'hF000, 16'h2000, 16'hFFFF, 1'b1};
    vecs[3]  = '{3'd1, 16'h0001, 16'h0002, 16'h0003, 1'b0};
    vecs[4]  = '{3'd2, 16'h0003, 16'h0008, 16'h0005, 1'b0};
    vecs[5]  = '{3'd2, 16'h0008, 16'h0003, 16'h0005, 1'b0};
    vecs[6]  = '{3'd2, 16'h0042, 16'h0042, 16'h0000, 1'b0};
    vecs[7]  = '{3'd3, 16'h00F0, 16'h0030, 16'h0030, 1'b0};
    vecs[8]  = '{3'd3, 16'h0030, 16'h00F0, 16'h00C0, 1'b0};
    vecs[9]  = '{3'd4, 16'h8001, 16'h0001, 16'h0002, 1'b1};
    vecs[10] = '{3'd4, 16'h8001, 16'h0000, 16'h4000, 1'b1};
    vecs[11] = '{3'd4, 16'h0002, 16'h0000, 16'h0001, 1'b0};
    vecs[12] = '{3'd6, 16'h1234, 16'h4321, 16'h4321, 1'b0};
    vecs[13] = '{3'd7, 16'h00FF, 16'h1234, 16'hFF00, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; din1 = '0; din2 = '0; mode = 3'd0;
    acc_clr = 1'b0; out_ready = 1'b1;
    #3;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_data_out", 64'(dout), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Latency: accept at edge N, out_valid absent after N, present after N+1
    send(3'd0, 16'hFFFF, 16'h0002, 16'h0001, 1'b1);
    @(negedge clk);
    chk("lat_not_yet", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("lat_valid", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    drain();

    // Accumulator: three increments, then clear coincident with a mode-5 load
    send(3'd5, 16'h0001, 16'h0000, 16'h0001, 1'b0);
    send(3'd5, 16'h0001, 16'h0000, 16'h0002, 1'b0);
    send(3'd5, 16'h0001, 16'h0000, 16'h0003, 1'b0);
    send(3'd5, 16'h0007, 16'h0000, 16'h0007, 1'b0);
    acc_clr = 1'b1;
    @(posedge clk); #1;
    acc_clr = 1'b0;
    drain();

    // Table vectors, back to back
    for (int i = 0; i < 14; i++) begin
      send(vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].o);
    end
    drain();

    // Back-pressure: two accepts, then out_ready low for three cycles
    send(3'd0, 16'h0010, 16'h0001, 16'h0011, 1'b0);
    send(3'd0, 16'h0020, 16'h0002, 16'h0022, 1'b0);
    out_ready = 1'b0;
    fork
      begin
        send(3'd0, 16'h0030, 16'h0003, 16'h0033, 1'b0);
        send(3'd0, 16'h0040, 16'h0004, 16'h0044, 1'b0);
      end
      begin
        logic [W-1:0] held;
        @(negedge clk);
        held = dout;
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        for (int k = 0; k < 2; k++) begin
          @(negedge clk);
          chk("stall_in_ready", 64'(in_ready), 64'd0);
          chk("stall_data_hold", 64'(dout), 64'(held));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Random stream with random back-pressure (accumulator mode excluded)
    begin
      bit done = 1'b0;
      fork
        begin
          for (int i = 0; i < 40; i++) begin
            logic [2:0] m;
            logic [W-1:0] a, b;
            exp_t e;
            m = 3'($urandom_range(0, 6));
            if (m == 3'd5) m = 3'd7;
            a = 16'($urandom);
            b = 16'($urandom);
            e = model(m, a, b);
            send(m, a, b, e.d, e.o);
          end
          done = 1'b1;
        end
        begin
          while (!done) begin
            @(posedge clk); #1;
            out_ready = 1'($urandom_range(0, 1));
          end
        end
      join
    end
    drain();

    // Reset with two operations in flight
    send(3'd0, 16'h0100, 16'h0001, 16'h0101, 1'b0);
    send(3'd0, 16'h0200, 16'h0002, 16'h0202, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_data_out", 64'(dout), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    sb_q.delete();
    pushed = popped;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("no_stale_out", 64'(out_valid), 64'd0);
    end
    @(posedge clk); #1;
    send(3'd6, 16'h0005, 16'h0009, 16'h0009, 1'b0);
    drain();

    chk("result_count", 64'(popped), 64'(pushed));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
